// File: rtl/handshake_pkg.sv
// Shared types and helpers for the 4-phase req/ack transmitter.
package handshake_pkg;

  typedef enum logic [1:0] {
    HS_IDLE    = 2'd0,
    HS_REQ     = 2'd1,
    HS_RELEASE = 2'd2
  } hs_state_t;

  // Phase counter width; a disabled timeout (0) still needs one bit.
  function automatic int cnt_width(input int max_cycles);
    return (max_cycles > 0) ? $clog2(max_cycles + 1) : 1;
  endfunction

endpackage

// File: rtl/sync_2ff_n.sv
// Two-flop synchronizer for signals arriving from an unrelated clock domain.
module sync_2ff_n #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_p0;
  logic [WIDTH-1:0] sync_p1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/handshake_tx.sv
// Transmitting side of a 4-phase req/ack crossing: holds a word on data_out
// under req_out and waits for the synchronized acknowledge to complete.
module handshake_tx
  import handshake_pkg::*;
#(
  parameter int WIDTH          = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tx_valid,
  input  logic [WIDTH-1:0] tx_data,
  output logic             tx_ready,
  output logic             tx_done,
  output logic             req_out,
  output logic [WIDTH-1:0] data_out,
  input  logic             ack_async,
  output logic             timeout_err,
  input  logic             err_clear
);

  localparam int              CNT_W   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  hs_state_t        state;
  hs_state_t        state_nxt;
  logic             ack_s;
  logic             accept;
  logic             done_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             err_set;

  // Stage: acknowledge synchronization
  sync_2ff_n #(.WIDTH(1)) u_ack_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ack_async),
    .q     (ack_s)
  );

  // A stale ack left high (e.g. after a mid-handshake reset) blocks new words.
  assign tx_ready = (state == HS_IDLE) && !ack_s;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    done_nxt  = 1'b0;
    case (state)
      HS_IDLE: begin
        if (tx_valid && tx_ready) begin
          accept    = 1'b1;
          state_nxt = HS_REQ;
        end
      end
      HS_REQ: begin
        if (ack_s) state_nxt = HS_RELEASE;
      end
      HS_RELEASE: begin
        if (!ack_s) begin
          state_nxt = HS_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = HS_IDLE;
    endcase
  end

  // Timeout only flags the stall; the handshake itself is never abandoned.
  always_comb begin
    cnt_nxt = cnt;
    err_set = 1'b0;
    if (state_nxt != state) begin
      cnt_nxt = '0;
    end else if (state != HS_IDLE) begin
      cnt_nxt = sat_inc(cnt);
      err_set = (TIMEOUT_CYCLES != 0) && (cnt != CNT_MAX) && (cnt_nxt == CNT_MAX);
    end
  end

  // Stage: control registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= HS_IDLE;
      req_out     <= 1'b0;
      tx_done     <= 1'b0;
      cnt         <= '0;
      timeout_err <= 1'b0;
    end else begin
      state   <= state_nxt;
      req_out <= (state_nxt == HS_REQ);
      tx_done <= done_nxt;
      cnt     <= cnt_nxt;
      if (err_set) begin
        timeout_err <= 1'b1;
      end else if (err_clear) begin
        timeout_err <= 1'b0;
      end
    end
  end

  // Stage: data register, loaded only on accept so it is stable for the far side
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out <= '0;
    end else if (accept) begin
      data_out <= tx_data;
    end
  end

endmodule

// File: tb/tb_handshake_tx.sv
// Bench for handshake_tx: directed scenarios plus randomized traffic against a cycle-level reference model.
module tb_handshake_tx;

  localparam int W = 8;
  localparam int T = 16;

  logic         clk = 1'b0;
  logic         reset;
  logic         tx_valid;
  logic [W-1:0] tx_data;
  logic         tx_ready;
  logic         tx_done;
  logic         req_out;
  logic [W-1:0] data_out;
  logic         ack_async;
  logic         timeout_err;
  logic         err_clear;

  always #5 clk = ~clk;

  handshake_tx #(.WIDTH(W), .TIMEOUT_CYCLES(T)) dut (
    .clk         (clk),
    .reset       (reset),
    .tx_valid    (tx_valid),
    .tx_data     (tx_data),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .req_out     (req_out),
    .data_out    (data_out),
    .ack_async   (ack_async),
    .timeout_err (timeout_err),
    .err_clear   (err_clear)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: phase 0 idle, 1 requesting, 2 releasing; ack seen through a 2-deep delay line.
  int         m_phase;
  bit         m_ack_d[2];
  bit [W-1:0] m_data;
  bit         m_done;
  bit         m_err;
  int         m_cnt;
  bit         m_acc;
  bit [W-1:0] exp_q[$];
  bit [W-1:0] rx_q[$];

  bit far_en;
  int far_wait;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_ack_d[0] = 1'b0;
    m_ack_d[1] = 1'b0;
    m_data = '0;
    m_done = 1'b0;
    m_err = 1'b0;
    m_cnt = 0;
    m_acc = 1'b0;
    exp_q.delete();
  endtask

  task automatic check_outputs();
    chk("req_out", req_out, m_phase == 1);
    chk("data_out", data_out, m_data);
    chk("tx_ready", tx_ready, (m_phase == 0) && !m_ack_d[1]);
    chk("tx_done", tx_done, m_done);
    chk("timeout_err", timeout_err, m_err);
  endtask

  // Far-side receiver: follows req_out with a random delay, sampling data on its ack rise.
  task automatic far_side();
    if (!far_en) return;
    if (ack_async != req_out) begin
      if (far_wait == 0) far_wait = $urandom_range(1, 4);
      far_wait--;
      if (far_wait == 0) begin
        if (req_out) begin
          chk("rx_pending", exp_q.size() > 0, 1);
          if (exp_q.size() > 0) chk("rx_word", data_out, exp_q.pop_front());
          rx_q.push_back(data_out);
        end
        ack_async = req_out;
      end
    end else begin
      far_wait = 0;
    end
  endtask

  task automatic step();
    bit         pv;
    bit         pa;
    bit         pc;
    bit         set;
    bit [W-1:0] pd;
    int         nphase;
    pv = tx_valid;
    pd = tx_data;
    pa = ack_async;
    pc = err_clear;
    @(posedge clk);
    m_acc  = 1'b0;
    m_done = 1'b0;
    set    = 1'b0;
    nphase = m_phase;
    case (m_phase)
      0: if (pv && !m_ack_d[1]) begin
           nphase = 1;
           m_data = pd;
           exp_q.push_back(pd);
           m_acc = 1'b1;
         end
      1: if (m_ack_d[1]) nphase = 2;
      default: if (!m_ack_d[1]) begin
           nphase = 0;
           m_done = 1'b1;
         end
    endcase
    if (nphase != m_phase) begin
      m_cnt = 0;
    end else if (m_phase != 0 && m_cnt < T) begin
      m_cnt++;
      set = (m_cnt == T);
    end
    if (set) m_err = 1'b1;
    else if (pc) m_err = 1'b0;
    m_phase = nphase;
    m_ack_d[1] = m_ack_d[0];
    m_ack_d[0] = pa;
    @(negedge clk);
    check_outputs();
    far_side();
  endtask

  initial begin
    int i;
    int g;
    int k;
    int dn;
    int sent;
    reset = 1'b0;
    tx_valid = 1'b0;
    tx_data = '0;
    err_clear = 1'b0;
    ack_async = 1'b1;
    far_en = 1'b0;
    far_wait = 0;
    model_reset();
    rx_q.delete();
    repeat (3) @(negedge clk);
    check_outputs();

    // Reset release with a stale ack held high
    reset = 1'b1;
    repeat (4) step();
    chk("stale_ack_ready", tx_ready, 0);
    ack_async = 1'b0;
    repeat (3) step();
    chk("ready_after_ack_low", tx_ready, 1);

    // Single word, ack raised 3 cycles after req
    tx_valid = 1'b1;
    tx_data = 8'hA5;
    step();
    tx_valid = 1'b0;
    tx_data = W'($urandom);
    chk("single_req", req_out, 1);
    repeat (3) step();
    ack_async = 1'b1;
    k = 0;
    while (req_out && k < 10) begin
      step();
      k++;
    end
    chk("req_fall_latency_ok", (k >= 2) && (k <= 3), 1);
    chk("single_data_held", data_out, 8'hA5);
    ack_async = 1'b0;
    dn = 0;
    repeat (8) begin
      step();
      dn += int'(tx_done);
    end
    chk("single_done_pulses", dn, 1);
    exp_q.delete();

    // Back-to-back words with tx_valid held
    far_en = 1'b1;
    rx_q.delete();
    i = 0;
    g = 0;
    tx_valid = 1'b1;
    tx_data = 8'h01;
    while (i < 3 && g < 200) begin
      step();
      g++;
      if (m_acc) begin
        i++;
        tx_data = W'(i + 1);
      end
    end
    tx_valid = 1'b0;
    chk("b2b_accepted", i, 3);
    repeat (20) step();
    chk("b2b_rx_count", rx_q.size(), 3);
    for (int j = 0; j < 3 && j < rx_q.size(); j++) chk("b2b_rx_order", rx_q[j], j + 1);

    // Randomized traffic
    rx_q.delete();
    sent = 0;
    repeat (600) begin
      if (!tx_valid) begin
        tx_valid = ($urandom_range(0, 2) != 0);
        tx_data = W'($urandom);
      end
      err_clear = ($urandom_range(0, 15) == 0);
      step();
      if (m_acc) begin
        sent++;
        tx_valid = 1'b0;
      end
    end
    tx_valid = 1'b0;
    err_clear = 1'b0;
    repeat (20) step();
    chk("rand_all_delivered", exp_q.size(), 0);
    chk("rand_rx_count", rx_q.size(), sent);

    // Timeout: no ack, flag after T cycles of REQ, handshake still alive
    far_en = 1'b0;
    tx_valid = 1'b1;
    tx_data = W'($urandom);
    step();
    tx_valid = 1'b0;
    k = 0;
    g = 0;
    while (!timeout_err && g < 100) begin
      if (req_out) k++;
      step();
      g++;
    end
    chk("timeout_req_cycles", k, T);
    chk("timeout_req_held", req_out, 1);
    repeat (5) step();
    chk("timeout_still_req", req_out, 1);
    far_en = 1'b1;
    repeat (20) step();
    chk("late_ack_complete", exp_q.size(), 0);
    chk("timeout_sticky", timeout_err, 1);
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("err_cleared", timeout_err, 0);

    // Set and clear on the same edge: set wins
    far_en = 1'b0;
    tx_valid = 1'b1;
    tx_data = W'($urandom);
    step();
    tx_valid = 1'b0;
    g = 0;
    while (m_cnt != T - 1 && g < 100) begin
      step();
      g++;
    end
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;
    chk("set_wins_over_clear", timeout_err, 1);
    far_en = 1'b1;
    repeat (20) step();
    err_clear = 1'b1;
    step();
    err_clear = 1'b0;

    // Asynchronous reset while requesting
    far_en = 1'b0;
    tx_valid = 1'b1;
    tx_data = 8'h3C;
    step();
    tx_valid = 1'b0;
    step();
    chk("mid_req_active", req_out, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    chk("async_req_drop", req_out, 0);
    chk("async_data_clear", data_out, 0);
    chk("async_ready_idle", tx_ready, 1);
    model_reset();
    @(negedge clk);
    check_outputs();
    reset = 1'b1;
    repeat (5) step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
